warp_mem_responder: RTL and testbench
=====================================

// Module: warp_mem_responder
// PURPOSE
//  Memory-side responder for the warp engine's mem_req/mem_resp port: word-addressed SRAM model with fixed read latency and in-order responses.
//  Sits opposite the engine's instruction fetch path and answers kernel fetch reads with mem_resp_valid/data.
//  Host/testbench backdoor preloads kernel images. Used in SoC-less integration and as the reference slave for the engine bench.
// PARAMETERS
//  ADDR_WIDTH       32    byte-address width of mem_req_addr
//  DATA_WIDTH       32    word width
//  MEM_WORDS        1024  SRAM depth in words; power of two
//  READ_LATENCY     2     cycles from read accept to earliest mem_resp_valid; >=1
//  RESP_FIFO_DEPTH  4     max outstanding reads (pipeline + response FIFO); power of two, >=READ_LATENCY
// PORTS
//  clk             in   1           clock
//  rst             in   1           synchronous reset, active-high
//  mem_req_valid   in   1           request valid
//  mem_req_ready   out  1           request accepted when valid&&ready
//  mem_req_addr    in   ADDR_WIDTH  byte address; word index = addr[ADDR_WIDTH-1:2], addr[1:0] ignored
//  mem_req_write   in   1           1=write (no response), 0=read
//  mem_req_data    in   DATA_WIDTH  write data
//  mem_resp_valid  out  1           read data valid
//  mem_resp_ready  in   1           consumer ready
//  mem_resp_data   out  DATA_WIDTH  read data, in request order
//  load_en         in   1           backdoor write strobe
//  load_addr       in   ADDR_WIDTH  backdoor word index, not a byte address
//  load_data       in   DATA_WIDTH  backdoor write data
//  err             out  1           sticky out-of-range flag; see CONFIGURATION
// BEHAVIOUR
//  Reset: mem_req_ready=0, mem_resp_valid=0, mem_resp_data=0, err=0, outstanding=0. Pipeline valids are cleared and the FIFO is emptied.
//   SRAM contents are not reset.
//  Reset mid-operation: all in-flight reads are dropped, with no stale response after rst deasserts. mem_req_ready rises the cycle after rst falls.
//  mem_req_ready = !rst && !load_en && (outstanding < RESP_FIFO_DEPTH). Combinational from registered state plus load_en; never depends on mem_req_valid.
//  Write accept: SRAM updated at the accepting edge, no response, outstanding unchanged. A read accepted in any later cycle returns the new data.
//  Read accept: outstanding+1; SRAM read enters a READ_LATENCY-stage valid/data shift pipe.
//   Accept in cycle t -> response pushed so mem_resp_valid can be 1 in cycle t+READ_LATENCY.
//  Pipe tail pushes into the response FIFO (warp_resp_fifo). mem_resp_valid = FIFO non-empty; mem_resp_data = FIFO head (0 when empty).
//  Response handshake mem_resp_valid&&mem_resp_ready: pop, outstanding-1.
//  Simultaneous read accept and response pop: outstanding unchanged. Sustained throughput is 1 read/cycle when mem_resp_ready=1.
//  The outstanding credit guarantees the FIFO never overflows. FIFO full with the pipe tail valid is unreachable and is asserted against.
//  Pipe→FIFO push and FIFO pop in the same cycle are both legal, including when the FIFO is full.
//  load_en: writes SRAM[load_addr mod MEM_WORDS] at the edge. It blocks request acceptance in that cycle, so a load and a request never collide.
//  In-flight reads still complete while load_en is high.
//  outstanding counter width: $clog2(RESP_FIFO_DEPTH)+1, no wrap.
//  No FSM. State is the credit counter, pipe valids, and FIFO wr/rd pointers with an extra wrap bit for full/empty.
// CONFIGURATION
//  `WARP_MEM_BOUNDS_CHECK_EN defined:
//   - Request word index >= MEM_WORDS is out of range.
//   - Out-of-range read returns MEM_ERR_PATTERN (32'hDEAD_BEEF) with normal latency.
//   - Out-of-range write is dropped.
//   - err sets at the accepting edge and holds until rst.
//  Not defined: index taken mod MEM_WORDS (wrap-around, upper bits ignored), and err is tied 0.
// STRUCTURE
//  warp_pkg additions: MEM_ERR_PATTERN; mem_req_t struct {addr, write, data}; function word_idx(addr).
//  Sub-module warp_resp_fifo: synchronous FIFO with active-high synchronous reset, parameters DEPTH/WIDTH, ports push/pop/data_in/data_out/full/empty.
//  Top holds the SRAM array, read pipe, credit counter, load port, and bounds logic.
// TESTING
//  1 Preload index 0..3 = 11,22,33,44 via load port. Read 0x0,0x4,0x8,0xC back-to-back with resp_ready=1
//    -> responses 11,22,33,44 in order, first in cycle accept+2, one per cycle after.
//  2 resp_ready=0, six reads offered -> exactly 4 accepted, then mem_req_ready=0.
//    Raise resp_ready -> 4 responses in order; mem_req_ready returns 1 the cycle after the first pop.
//  3 Write 0xCAFE_F00D @0x40, then read 0x40 next cycle -> 0xCAFE_F00D; no response produced for the write.
//  4 Read byte addr 4*MEM_WORDS after preloading index 0 = 0x1234.
//    With _EN -> 0xDEAD_BEEF and err=1, still 1 after 10 idle cycles. Without -> 0x1234 and err=0.
//  5 Two reads in flight, assert rst for 1 cycle -> mem_resp_valid stays 0 throughout.
//    mem_req_ready=1 the cycle after rst falls; next read returns correct data.
//  6 load_en=1 while mem_req_valid=1 -> no accept that cycle. Request accepted the next cycle and reads the freshly loaded word.

Source files
------------

// File: rtl/warp_pkg.sv
// Shared types and constants for the warp engine memory port.
// Fixed at a 32-bit byte-address and 32-bit data port.
package warp_pkg;

   localparam int WARP_AW = 32;
   localparam int WARP_DW = 32;

   localparam logic [WARP_DW-1:0] MEM_ERR_PATTERN = 32'hDEAD_BEEF;

   typedef struct packed {
      logic [WARP_AW-1:0] addr;
      logic               write;
      logic [WARP_DW-1:0] data;
   } mem_req_t;

   // Byte address to word index; the two byte-lane bits are dropped.
   function automatic logic [WARP_AW-1:0] word_idx(input logic [WARP_AW-1:0] addr);
      return addr >> 2;
   endfunction

endpackage

// File: rtl/warp_resp_fifo.sv
// Synchronous response FIFO, wrap-bit pointers for full/empty, head zeroed when empty.
// Latency: data pushed at an edge is visible at the head in the next cycle.
// Backpressure: push while full is taken only together with a pop; pop while empty is ignored.
module warp_resp_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || pop);
   assign data_out = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= data_in;
   end

endmodule

// File: rtl/warp_mem_responder.sv
// Word-addressed SRAM slave for the warp mem port; `WARP_MEM_BOUNDS_CHECK_EN enables range checking.
// Latency: read accepted in cycle t can respond in cycle t+READ_LATENCY, in request order.
// Backpressure: credit of RESP_FIFO_DEPTH outstanding reads; ready drops when exhausted or load_en is high.
module warp_mem_responder
   import warp_pkg::*;
#(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MEM_WORDS       = 1024,
   parameter int READ_LATENCY    = 2,
   parameter int RESP_FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_req_valid,
   output logic                  mem_req_ready,
   input  logic [ADDR_WIDTH-1:0] mem_req_addr,
   input  logic                  mem_req_write,
   input  logic [DATA_WIDTH-1:0] mem_req_data,
   output logic                  mem_resp_valid,
   input  logic                  mem_resp_ready,
   output logic [DATA_WIDTH-1:0] mem_resp_data,
   input  logic                  load_en,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic [DATA_WIDTH-1:0] load_data,
   output logic                  err
);

   localparam int IW = $clog2(MEM_WORDS);
   localparam int CW = $clog2(RESP_FIFO_DEPTH) + 1;

   mem_req_t              req;
   logic [WARP_AW-1:0]    idx_full;
   logic [IW-1:0]         idx;
   logic                  in_range;
   logic                  acc;
   logic                  rd_acc;
   logic                  wr_acc;
   logic                  wr_ok;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [CW-1:0]         outstanding;
   logic [DATA_WIDTH-1:0] sram [MEM_WORDS];
   logic                  tail_vld;
   logic [DATA_WIDTH-1:0] tail_dat;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  pop;
   logic [DATA_WIDTH-1:0] fifo_head;
   logic                  unused_load;

   assign req = '{addr: WARP_AW'(mem_req_addr), write: mem_req_write, data: WARP_DW'(mem_req_data)};

   assign idx_full = word_idx(req.addr);
   assign idx      = idx_full[IW-1:0];
   assign in_range = (idx_full < WARP_AW'(MEM_WORDS));

   assign mem_req_ready = !rst && !load_en && (outstanding < CW'(RESP_FIFO_DEPTH));
   assign acc    = mem_req_valid && mem_req_ready;
   assign rd_acc = acc && !req.write;
   assign wr_acc = acc && req.write;

   assign unused_load = ^load_addr[ADDR_WIDTH-1:IW];

`ifdef WARP_MEM_BOUNDS_CHECK_EN
   logic err_q;

   assign wr_ok   = in_range;
   assign rd_word = in_range ? sram[idx] : DATA_WIDTH'(MEM_ERR_PATTERN);
   assign err     = err_q;

   always_ff @(posedge clk) begin
      if (rst)                   err_q <= 1'b0;
      else if (acc && !in_range) err_q <= 1'b1;
   end
`else
   logic unused_range;

   assign wr_ok        = 1'b1;
   assign rd_word      = sram[idx];
   assign err          = 1'b0;
   assign unused_range = ^{in_range, idx_full[WARP_AW-1:IW]};
`endif

   // load_en blocks acceptance, so the two write sources never hit the same edge.
   always_ff @(posedge clk) begin
      if (load_en)         sram[load_addr[IW-1:0]] <= load_data;
      if (wr_acc && wr_ok) sram[idx]               <= DATA_WIDTH'(req.data);
   end

   // The FIFO register supplies the last cycle of latency, so the pipe is one stage short.
   generate
      if (READ_LATENCY == 1) begin : g_nopipe
         assign tail_vld = rd_acc;
         assign tail_dat = rd_word;
      end else begin : g_pipe
         logic [READ_LATENCY-2:0] vld_q;
         logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY-1];

         always_ff @(posedge clk) begin
            if (rst) begin
               vld_q <= '0;
            end else begin
               vld_q[0] <= rd_acc;
               for (int k = 1; k < READ_LATENCY - 1; k++) vld_q[k] <= vld_q[k-1];
            end
         end

         always_ff @(posedge clk) begin
            dat_q[0] <= rd_word;
            for (int k = 1; k < READ_LATENCY - 1; k++) dat_q[k] <= dat_q[k-1];
         end

         assign tail_vld = vld_q[READ_LATENCY-2];
         assign tail_dat = dat_q[READ_LATENCY-2];
      end
   endgenerate

   warp_resp_fifo #(
      .DEPTH (RESP_FIFO_DEPTH),
      .WIDTH (DATA_WIDTH)
   ) u_resp_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (tail_vld),
      .pop      (pop),
      .data_in  (tail_dat),
      .data_out (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign mem_resp_valid = !rst && !fifo_empty;
   assign mem_resp_data  = mem_resp_valid ? fifo_head : '0;
   assign pop            = mem_resp_valid && mem_resp_ready;

   always_ff @(posedge clk) begin
      if (rst) outstanding <= '0;
      else     outstanding <= outstanding + CW'(rd_acc) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (!rst) assert (!(tail_vld && fifo_full));
   end

endmodule

// File: tb/tb_warp_mem_responder.sv
// Scoreboard bench for warp_mem_responder: expected read data queued at accept, checked at response.
module tb_warp_mem_responder;

   localparam int MW = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_req_valid = 1'b0;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr = '0;
   logic        mem_req_write = 1'b0;
   logic [31:0] mem_req_data = '0;
   logic        mem_resp_valid;
   logic        mem_resp_ready = 1'b1;
   logic [31:0] mem_resp_data;
   logic        load_en = 1'b0;
   logic [31:0] load_addr = '0;
   logic [31:0] load_data = '0;
   logic        err;

   int          n_vec = 0;
   int          n_bad = 0;
   int          cyc = 0;
   logic [31:0] exp_q[$];
   int          resp_cyc[$];
   logic [31:0] model [MW];
   bit          watch = 1'b0;
   bit          leak = 1'b0;

   warp_mem_responder dut (
      .clk            (clk),
      .rst            (rst),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_req_write  (mem_req_write),
      .mem_req_data   (mem_req_data),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_ready (mem_resp_ready),
      .mem_resp_data  (mem_resp_data),
      .load_en        (load_en),
      .load_addr      (load_addr),
      .load_data      (load_data),
      .err            (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mem_resp_valid && mem_resp_ready) begin
         resp_cyc.push_back(cyc);
         if (exp_q.size() == 0) check("spurious_resp", {31'b0, mem_resp_valid}, 32'd0);
         else                   check("resp_data", mem_resp_data, exp_q.pop_front());
      end
      if (watch && mem_resp_valid) leak = 1'b1;
   end

   function automatic logic [31:0] exp_rd(input logic [31:0] addr);
      logic [31:0] w;
      w = addr >> 2;
`ifdef WARP_MEM_BOUNDS_CHECK_EN
      if (w >= MW) return 32'hDEAD_BEEF;
`endif
      return model[w % MW];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int idx, input logic [31:0] d);
      load_en   = 1'b1;
      load_addr = idx;
      load_data = d;
      model[idx % MW] = d;
      tick();
      load_en = 1'b0;
   endtask

   task automatic request(input logic [31:0] addr, input logic wr, input logic [31:0] d);
      bit done;
      logic [31:0] w;
      done = 1'b0;
      mem_req_valid = 1'b1;
      mem_req_addr  = addr;
      mem_req_write = wr;
      mem_req_data  = d;
      for (int n = 0; n < 20 && !done; n++) begin
         @(negedge clk);
         if (mem_req_ready) begin
            done = 1'b1;
            w = addr >> 2;
            if (!wr) exp_q.push_back(exp_rd(addr));
`ifdef WARP_MEM_BOUNDS_CHECK_EN
            else if (w < MW) model[w % MW] = d;
`else
            else model[w % MW] = d;
`endif
         end
         tick();
      end
      mem_req_valid = 1'b0;
      mem_req_write = 1'b0;
      if (!done) check("req_timeout", {31'b0, mem_req_ready}, 32'd1);
   endtask

   task automatic drain();
      for (int n = 0; n < 50 && exp_q.size() > 0; n++) tick();
      check("drain", exp_q.size(), 32'd0);
   endtask

   initial begin
      int acc_cyc [4];
      int n_acc;
      int base;

      for (int i = 0; i < MW; i++) model[i] = '0;

      // reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", {31'b0, mem_req_ready}, 32'd0);
      check("rst_resp_valid", {31'b0, mem_resp_valid}, 32'd0);
      check("rst_resp_data", mem_resp_data, 32'd0);
      check("rst_err", {31'b0, err}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rdy_after_rst", {31'b0, mem_req_ready}, 32'd1);
      tick();
      for (int i = 0; i < MW; i++) load(i, 32'h0F00_0000 + i);

      // 1: back-to-back reads, latency 2, one per cycle
      load(0, 32'd11); load(1, 32'd22); load(2, 32'd33); load(3, 32'd44);
      mem_resp_ready = 1'b1;
      resp_cyc.delete();
      for (int i = 0; i < 4; i++) begin
         mem_req_valid = 1'b1;
         mem_req_addr  = i * 4;
         mem_req_write = 1'b0;
         @(negedge clk);
         check("t1_ready", {31'b0, mem_req_ready}, 32'd1);
         acc_cyc[i] = cyc;
         exp_q.push_back(model[i]);
         tick();
      end
      mem_req_valid = 1'b0;
      drain();
      check("t1_resp_count", resp_cyc.size(), 32'd4);
      for (int i = 0; i < 4 && i < resp_cyc.size(); i++)
         check("t1_latency", resp_cyc[i] - acc_cyc[i], 32'd2);

      // 2: credit limit with consumer stalled
      mem_resp_ready = 1'b0;
      n_acc = 0;
      for (int i = 0; i < 6; i++) begin
         mem_req_valid = 1'b1;
         mem_req_addr  = i * 4;
         @(negedge clk);
         if (mem_req_ready) begin
            n_acc++;
            exp_q.push_back(model[i]);
         end
         tick();
      end
      mem_req_valid = 1'b0;
      check("t2_accepts", n_acc, 32'd4);
      @(negedge clk);
      check("t2_ready_low", {31'b0, mem_req_ready}, 32'd0);
      tick();
      mem_resp_ready = 1'b1;
      @(negedge clk);
      check("t2_ready_pop_cycle", {31'b0, mem_req_ready}, 32'd0);
      tick();
      @(negedge clk);
      check("t2_ready_back", {31'b0, mem_req_ready}, 32'd1);
      drain();

      // 3: write then read, no response for the write
      base = resp_cyc.size();
      request(32'h40, 1'b1, 32'hCAFE_F00D);
      request(32'h40, 1'b0, 32'h0);
      drain();
      repeat (3) tick();
      check("t3_resp_count", resp_cyc.size() - base, 32'd1);

      // 4: out-of-range read
      load(0, 32'h1234);
      request(4 * MW, 1'b0, 32'h0);
      drain();
      repeat (10) tick();
`ifdef WARP_MEM_BOUNDS_CHECK_EN
      check("t4_err", {31'b0, err}, 32'd1);
`else
      check("t4_err", {31'b0, err}, 32'd0);
`endif

      // 5: reset with reads in flight
      watch = 1'b1;
      leak  = 1'b0;
      mem_req_valid = 1'b1;
      mem_req_addr  = 32'h4;
      @(negedge clk);
      tick();
      mem_req_addr = 32'h8;
      @(negedge clk);
      tick();
      mem_req_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("t5_ready_after_rst", {31'b0, mem_req_ready}, 32'd1);
      repeat (5) tick();
      watch = 1'b0;
      check("t5_no_stale_resp", {31'b0, leak}, 32'd0);
      request(32'h4, 1'b0, 32'h0);
      drain();

      // 6: load blocks a same-cycle request, which then sees the loaded word
      load_en   = 1'b1;
      load_addr = 32'd7;
      load_data = 32'h7777_0007;
      model[7]  = 32'h7777_0007;
      mem_req_valid = 1'b1;
      mem_req_addr  = 32'h1C;
      mem_req_write = 1'b0;
      @(negedge clk);
      check("t6_blocked", {31'b0, mem_req_ready}, 32'd0);
      tick();
      load_en = 1'b0;
      @(negedge clk);
      check("t6_accept", {31'b0, mem_req_ready}, 32'd1);
      if (mem_req_ready) exp_q.push_back(model[7]);
      tick();
      mem_req_valid = 1'b0;
      drain();

      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
